// File: rtl/timer_csr.sv
// Bus-programmable prescaled timer with compare match, sticky STATUS.match and level IRQ.
// Reads return one cycle after req_i; no backpressure. Option TIMER_AUTORELOAD_EN enables CTRL.reload.
module timer_csr #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int PRESCALE_RST = 10000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  irq_o,
   output logic [DATA_WIDTH-1:0] count_o
);

   localparam logic [DATA_WIDTH-1:0] ONE           = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] PRESCALE_INIT = DATA_WIDTH'(PRESCALE_RST);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_PRESCALE = 3'd1;
   localparam logic [2:0] OFF_COUNT    = 3'd2;
   localparam logic [2:0] OFF_COMPARE  = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd4;

   logic                  en_q, en_d;
   logic                  irq_en_q, irq_en_d;
`ifdef TIMER_AUTORELOAD_EN
   logic                  reload_q, reload_d;
`endif
   logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] compare_q, compare_d;
   logic                  match_q, match_d;
   logic [DATA_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;

   logic [2:0]            off;
   logic                  wr, rd;
   logic                  wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status, clr_wr;
   logic [DATA_WIDTH-1:0] presc_eff, cnt_inc, ctrl_rd;
   logic                  tick, match_hit;
   logic                  unused_addr;

   assign off         = addr_i[4:2];
   assign unused_addr = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};
   assign wr          = req_i & we_i;
   assign rd          = req_i & ~we_i;
   assign wr_ctrl     = wr && (off == OFF_CTRL);
   assign wr_presc    = wr && (off == OFF_PRESCALE);
   assign wr_count    = wr && (off == OFF_COUNT);
   assign wr_cmp      = wr && (off == OFF_COMPARE);
   assign wr_status   = wr && (off == OFF_STATUS);
   assign clr_wr      = wr_ctrl && wdata_i[2];

   // A zero prescaler behaves as divide-by-one.
   assign presc_eff = (prescale_q == '0) ? ONE : prescale_q;
   assign tick      = en_q && (pre_cnt_q == presc_eff - ONE);
   assign cnt_inc   = count_q + ONE;
   assign match_hit = tick && (cnt_inc == compare_q);

   always_comb begin
      ctrl_rd    = '0;
      ctrl_rd[0] = en_q;
      ctrl_rd[1] = irq_en_q;
`ifdef TIMER_AUTORELOAD_EN
      ctrl_rd[3] = reload_q;
`endif
   end

   always_comb begin
      en_d       = en_q;
      irq_en_d   = irq_en_q;
`ifdef TIMER_AUTORELOAD_EN
      reload_d   = reload_q;
`endif
      prescale_d = prescale_q;
      compare_d  = compare_q;
      pre_cnt_d  = pre_cnt_q;
      count_d    = count_q;
      match_d    = match_q;
      rdata_d    = rdata_q;
      rvalid_d   = rd;

      if (wr_ctrl) begin
         en_d     = wdata_i[0];
         irq_en_d = wdata_i[1];
`ifdef TIMER_AUTORELOAD_EN
         reload_d = wdata_i[3];
`endif
      end
      if (wr_presc) prescale_d = wdata_i;
      if (wr_cmp)   compare_d  = wdata_i;

      if (clr_wr || wr_presc)  pre_cnt_d = '0;
      else if (tick)           pre_cnt_d = '0;
      else if (en_q)           pre_cnt_d = pre_cnt_q + ONE;

      if (clr_wr)        count_d = '0;
      else if (wr_count) count_d = wdata_i;
      else if (tick) begin
`ifdef TIMER_AUTORELOAD_EN
         count_d = (reload_q && match_hit) ? '0 : cnt_inc;
`else
         count_d = cnt_inc;
`endif
      end

      // Set takes precedence over the W1C; clr and COUNT writes suppress the match check.
      if (wr_status && wdata_i[0])               match_d = 1'b0;
      if (match_hit && !clr_wr && !wr_count)     match_d = 1'b1;

      if (rd) begin
         case (off)
            OFF_CTRL:     rdata_d = ctrl_rd;
            OFF_PRESCALE: rdata_d = prescale_q;
            OFF_COUNT:    rdata_d = count_q;
            OFF_COMPARE:  rdata_d = compare_q;
            OFF_STATUS:   rdata_d = {{(DATA_WIDTH-1){1'b0}}, match_q};
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
         reload_q   <= 1'b0;
`endif
         prescale_q <= PRESCALE_INIT;
         count_q    <= '0;
         compare_q  <= '1;
         match_q    <= 1'b0;
         pre_cnt_q  <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
`ifdef TIMER_AUTORELOAD_EN
         reload_q   <= reload_d;
`endif
         prescale_q <= prescale_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         match_q    <= match_d;
         pre_cnt_q  <= pre_cnt_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign irq_o    = match_q & irq_en_q;
   assign count_o  = count_q;

endmodule
